player_controller: RTL

PLAYER_CONTROLLER -- requirements
Module: player_controller

---
 rtl/player_pkg.sv | 18 +
 rtl/player_controller_tick_gen.sv | 26 ++
 rtl/player_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared screen geometry, player_state codes and jump FSM encoding for the player controller.
package player_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [3:0] ST_STATIC = 4'd6;
    localparam logic [3:0] ST_RIGHT  = 4'd7;
    localparam logic [3:0] ST_LEFT   = 4'd8;
    localparam logic [3:0] ST_UP     = 4'd9;

    typedef enum logic [1:0] {
        JS_GROUND = 2'd0,
        JS_RISE   = 2'd1,
        JS_FALL   = 2'd2
    } jump_state_e;

endpackage

// File: rtl/player_controller_tick_gen.sv
// Game tick generator: a one-cycle pulse every TICK_DIV clk cycles, counting from zero after reset.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/player_controller.sv
// Player movement and jump controller, updated once per game tick.
// Optional build macro DOUBLE_JUMP_EN allows one extra mid-air jump.
module player_controller
    import player_pkg::*;
#(
    parameter int         TICK_DIV   = 1_000_000,
    parameter logic [9:0] START_X    = 10'd32,
    parameter logic [9:0] START_Y    = 10'd400,
    parameter int         STEP_X     = 2,
    parameter int         STEP_Y     = 3,
    parameter int         JUMP_TICKS = 20,
    parameter int         SPR_W      = 32,
    parameter int         SPR_H      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       blocked_left,
    input  logic       blocked_right,
    input  logic       blocked_up,
    input  logic       on_ground,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] player_state,
    output logic       jumping
);

    localparam logic [9:0] X_MAX  = 10'(SCREEN_W - SPR_W);
    localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - SPR_H);
    localparam logic [9:0] STEP_XV = 10'(STEP_X);
    localparam logic [9:0] STEP_YV = 10'(STEP_Y);
    localparam int         RC_W   = $clog2(JUMP_TICKS + 1);
    localparam logic [RC_W-1:0] RISE_LAST = RC_W'(JUMP_TICKS - 1);

    logic tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    jump_state_e     state_q, state_d;
    logic [RC_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [9:0]      pos_x_q, pos_x_d;
    logic [9:0]      pos_y_q, pos_y_d;
    logic [3:0]      player_state_q, player_state_d;
    logic            key_up_q, key_up_d;
`ifdef DOUBLE_JUMP_EN
    logic [1:0]      jumps_used_q, jumps_used_d;
`endif

    logic dir_right, dir_left, up_edge;
    logic [9:0] y_up, y_down;

    assign dir_right = key_right & ~key_left;
    assign dir_left  = key_left & ~key_right;
    // key_up_q only advances on ticks, so a held key yields a single edge.
    assign up_edge   = key_up & ~key_up_q;
    assign y_up      = (pos_y_q < STEP_YV) ? 10'd0 : pos_y_q - STEP_YV;
    assign y_down    = (pos_y_q > Y_MAX - STEP_YV) ? Y_MAX : pos_y_q + STEP_YV;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= JS_GROUND;
            rise_cnt_q     <= '0;
            pos_x_q        <= START_X;
            pos_y_q        <= START_Y;
            player_state_q <= ST_STATIC;
            key_up_q       <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            jumps_used_q   <= 2'd0;
`endif
        end else begin
            state_q        <= state_d;
            rise_cnt_q     <= rise_cnt_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            player_state_q <= player_state_d;
            key_up_q       <= key_up_d;
`ifdef DOUBLE_JUMP_EN
            jumps_used_q   <= jumps_used_d;
`endif
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        if (tick) begin
            if (dir_right && !blocked_right)
                pos_x_d = (pos_x_q > X_MAX - STEP_XV) ? X_MAX : pos_x_q + STEP_XV;
            else if (dir_left && !blocked_left)
                pos_x_d = (pos_x_q < STEP_XV) ? 10'd0 : pos_x_q - STEP_XV;
        end
    end

    always_comb begin
        state_d    = state_q;
        rise_cnt_d = rise_cnt_q;
        pos_y_d    = pos_y_q;
        key_up_d   = key_up_q;
`ifdef DOUBLE_JUMP_EN
        jumps_used_d = jumps_used_q;
`endif
        if (tick) begin
            key_up_d = key_up;
            case (state_q)
                JS_GROUND: begin
                    if (!on_ground) begin
                        state_d = JS_FALL;
                    end else if (up_edge) begin
                        state_d    = JS_RISE;
                        rise_cnt_d = '0;
`ifdef DOUBLE_JUMP_EN
                        jumps_used_d = 2'd1;
`endif
                    end
                end
                JS_RISE: begin
                    pos_y_d    = y_up;
                    rise_cnt_d = rise_cnt_q + 1'b1;
                    if (blocked_up || rise_cnt_q == RISE_LAST)
                        state_d = JS_FALL;
`ifdef DOUBLE_JUMP_EN
                    if (up_edge && jumps_used_q < 2'd2) begin
                        state_d      = JS_RISE;
                        rise_cnt_d   = '0;
                        jumps_used_d = jumps_used_q + 2'd1;
                    end
`endif
                end
                JS_FALL: begin
                    // Landing wins over a same-tick key_up edge; the jump is dropped.
                    if (on_ground) begin
                        state_d = JS_GROUND;
`ifdef DOUBLE_JUMP_EN
                        jumps_used_d = 2'd0;
`endif
                    end else begin
                        pos_y_d = y_down;
`ifdef DOUBLE_JUMP_EN
                        if (up_edge && jumps_used_q < 2'd2) begin
                            state_d      = JS_RISE;
                            rise_cnt_d   = '0;
                            jumps_used_d = jumps_used_q + 2'd1;
                        end
`endif
                    end
                end
                default: state_d = JS_GROUND;
            endcase
        end
    end

    always_comb begin
        jumping        = (state_q != JS_GROUND);
        player_state_d = player_state_q;
        if (tick) begin
            if (state_d != JS_GROUND) player_state_d = ST_UP;
            else if (dir_right)       player_state_d = ST_RIGHT;
            else if (dir_left)        player_state_d = ST_LEFT;
            else                      player_state_d = ST_STATIC;
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign player_state = player_state_q;

endmodule
